// File: rtl/if_fetch_pair.sv
// Dual-issue instruction fetch stage: owns the PC, issues one 64-bit SRAM request per packet,
// and presents up to two {adef,pc,inst} lines to the IF->ID queue.
module if_fetch_pair #(
  parameter int unsigned     PC_W     = 32,
  parameter int unsigned     INST_W   = 32,
  parameter logic [PC_W-1:0] RESET_PC = 'h1c000000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           allowin_i,
  input  logic                           branch_flush_i,
  input  logic [PC_W-1:0]                branch_target_i,
  input  logic                           excep_flush_i,
  input  logic [PC_W-1:0]                excep_entry_i,
  output logic                           inst_sram_req_o,
  output logic [PC_W-1:0]                inst_sram_addr_o,
  input  logic                           inst_sram_addr_ok_i,
  input  logic                           inst_sram_data_ok_i,
  input  logic [2*INST_W-1:0]            inst_sram_rdata_i,
  output logic                           line1_valid_o,
  output logic                           line2_valid_o,
  output logic [2*(1+PC_W+INST_W)-1:0]   to_id_obus
);

  localparam int unsigned LINE_W = 1 + PC_W + INST_W;

  typedef struct packed {
    logic              adef;
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } line_t;

  typedef enum logic [2:0] {
    S_REQ     = 3'd0,
    S_WAIT    = 3'd1,
    S_DISCARD = 3'd2,
    S_OUT     = 3'd3,
    S_HALT    = 3'd4
  } state_t;

  state_t          r_state, w_state_n;
  logic [PC_W-1:0] r_pc, w_pc_n;
  logic            r_req, w_req_n;
  logic            r_l1v, w_l1v_n;
  logic            r_l2v, w_l2v_n;
  line_t           r_line1, w_line1_n;
  line_t           r_line2, w_line2_n;

  logic w_flush;
  logic w_accept;
  logic w_misalign;

  assign w_flush    = excep_flush_i | branch_flush_i;
  assign w_accept   = r_req & inst_sram_addr_ok_i;
  assign w_misalign = (r_pc[1:0] != 2'b00);

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_REQ;
      r_pc    <= RESET_PC;
      r_req   <= 1'b0;
      r_l1v   <= 1'b0;
      r_l2v   <= 1'b0;
      r_line1 <= '0;
      r_line2 <= '0;
    end else begin
      r_state <= w_state_n;
      r_pc    <= w_pc_n;
      r_req   <= w_req_n;
      r_l1v   <= w_l1v_n;
      r_l2v   <= w_l2v_n;
      r_line1 <= w_line1_n;
      r_line2 <= w_line2_n;
    end
  end

  // Next-state, PC and output-line logic; a redirect overrides everything else
  always_comb begin
    w_state_n = r_state;
    w_pc_n    = r_pc;
    w_l1v_n   = r_l1v;
    w_l2v_n   = r_l2v;
    w_line1_n = r_line1;
    w_line2_n = r_line2;

    if (w_flush) begin
      w_pc_n  = excep_flush_i ? excep_entry_i : branch_target_i;
      w_l1v_n = 1'b0;
      w_l2v_n = 1'b0;
      unique case (r_state)
        S_REQ:     w_state_n = w_accept ? S_DISCARD : S_REQ;
        S_WAIT:    w_state_n = inst_sram_data_ok_i ? S_REQ : S_DISCARD;
        S_DISCARD: w_state_n = inst_sram_data_ok_i ? S_REQ : S_DISCARD;
        default:   w_state_n = S_REQ;
      endcase
    end else begin
      unique case (r_state)
        S_REQ: begin
          if (w_misalign) begin
            w_state_n = S_OUT;
            w_line1_n = '{adef: 1'b1, pc: r_pc, inst: '0};
            w_line2_n = '0;
            w_l1v_n   = 1'b1;
            w_l2v_n   = 1'b0;
          end else if (w_accept) begin
            w_state_n = S_WAIT;
          end
        end
        S_WAIT: begin
          if (inst_sram_data_ok_i) begin
            w_state_n = S_OUT;
            w_l1v_n   = 1'b1;
            if (!r_pc[2]) begin
              w_line1_n = '{adef: 1'b0, pc: r_pc, inst: inst_sram_rdata_i[INST_W-1:0]};
              w_line2_n = '{adef: 1'b0, pc: r_pc + PC_W'(4),
                            inst: inst_sram_rdata_i[2*INST_W-1:INST_W]};
              w_l2v_n   = 1'b1;
            end else begin
              w_line1_n = '{adef: 1'b0, pc: r_pc, inst: inst_sram_rdata_i[2*INST_W-1:INST_W]};
              w_line2_n = '0;
              w_l2v_n   = 1'b0;
            end
          end
        end
        S_DISCARD: begin
          if (inst_sram_data_ok_i) w_state_n = S_REQ;
        end
        S_OUT: begin
          if (allowin_i) begin
            w_l1v_n = 1'b0;
            w_l2v_n = 1'b0;
            if (r_line1.adef) begin
              w_state_n = S_HALT;
            end else begin
              w_state_n = S_REQ;
              w_pc_n    = r_pc + (r_l2v ? PC_W'(8) : PC_W'(4));
            end
          end
        end
        default: w_state_n = r_state;
      endcase
    end

    // Request is raised only from REQ with a word-aligned PC
    w_req_n = (w_state_n == S_REQ) && (w_pc_n[1:0] == 2'b00);
  end

  assign inst_sram_req_o  = r_req;
  assign inst_sram_addr_o = {r_pc[PC_W-1:3], 3'b000};
  assign line1_valid_o    = r_l1v;
  assign line2_valid_o    = r_l2v;
  assign to_id_obus       = {LINE_W'(r_line2), LINE_W'(r_line1)};

endmodule

// File: tb/tb_if_fetch_pair.sv
// Scoreboard bench for if_fetch_pair: a small SRAM/queue driver plus a PC model.
module tb_if_fetch_pair;

  localparam int unsigned LW = 65;

  logic         clk;
  logic         rst_n;
  logic         allowin_i;
  logic         branch_flush_i;
  logic [31:0]  branch_target_i;
  logic         excep_flush_i;
  logic [31:0]  excep_entry_i;
  logic         inst_sram_req_o;
  logic [31:0]  inst_sram_addr_o;
  logic         inst_sram_addr_ok_i;
  logic         inst_sram_data_ok_i;
  logic [63:0]  inst_sram_rdata_i;
  logic         line1_valid_o;
  logic         line2_valid_o;
  logic [129:0] to_id_obus;

  if_fetch_pair dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .allowin_i           (allowin_i),
    .branch_flush_i      (branch_flush_i),
    .branch_target_i     (branch_target_i),
    .excep_flush_i       (excep_flush_i),
    .excep_entry_i       (excep_entry_i),
    .inst_sram_req_o     (inst_sram_req_o),
    .inst_sram_addr_o    (inst_sram_addr_o),
    .inst_sram_addr_ok_i (inst_sram_addr_ok_i),
    .inst_sram_data_ok_i (inst_sram_data_ok_i),
    .inst_sram_rdata_i   (inst_sram_rdata_i),
    .line1_valid_o       (line1_valid_o),
    .line2_valid_o       (line2_valid_o),
    .to_id_obus          (to_id_obus)
  );

  typedef struct {
    logic          l2v;
    logic [LW-1:0] line1;
    logic [LW-1:0] line2;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        last_e;
  logic [31:0] m_pc;
  int          n_chk = 0;
  int          n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [129:0] got, input logic [129:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    int k;
    k = 0;
    while (!inst_sram_req_o && k < 20) begin
      tick();
      k++;
    end
    if (!inst_sram_req_o) check("req_timeout", 130'(0), 130'(1));
  endtask

  task automatic push_packet(input logic [31:0] pc, input logic [63:0] rd);
    exp_t e;
    if (!pc[2]) begin
      e.l2v   = 1'b1;
      e.line1 = {1'b0, pc, rd[31:0]};
      e.line2 = {1'b0, pc + 32'd4, rd[63:32]};
    end else begin
      e.l2v   = 1'b0;
      e.line1 = {1'b0, pc, rd[63:32]};
      e.line2 = '0;
    end
    sb_q.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb_q.size() == 0) begin
      check("sb_empty", 130'(0), 130'(1));
    end else begin
      e      = sb_q.pop_front();
      last_e = e;
      check("line1_valid", 130'(line1_valid_o), 130'(1));
      check("line2_valid", 130'(line2_valid_o), 130'(e.l2v));
      check("line1", 130'(to_id_obus[LW-1:0]), 130'(e.line1));
      if (e.l2v) check("line2", 130'(to_id_obus[2*LW-1:LW]), 130'(e.line2));
    end
  endtask

  task automatic do_fetch(input logic [63:0] rd);
    wait_req();
    check("addr", 130'(inst_sram_addr_o), 130'({m_pc[31:3], 3'b000}));
    inst_sram_addr_ok_i = 1'b1;
    tick();
    inst_sram_addr_ok_i = 1'b0;
    check("req_in_wait", 130'(inst_sram_req_o), 130'(0));
    inst_sram_data_ok_i = 1'b1;
    inst_sram_rdata_i   = rd;
    push_packet(m_pc, rd);
    tick();
    inst_sram_data_ok_i = 1'b0;
    pop_check();
  endtask

  task automatic transfer();
    allowin_i = 1'b1;
    tick();
    allowin_i = 1'b0;
    check("valid_after_xfer", 130'({line2_valid_o, line1_valid_o}), 130'(0));
    m_pc = m_pc + (last_e.l2v ? 32'd8 : 32'd4);
  endtask

  task automatic branch(input logic [31:0] tgt);
    branch_flush_i  = 1'b1;
    branch_target_i = tgt;
    tick();
    branch_flush_i  = 1'b0;
    m_pc = tgt;
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b0;
    allowin_i = 1'b0;
    branch_flush_i = 1'b0;
    branch_target_i = '0;
    excep_flush_i = 1'b0;
    excep_entry_i = '0;
    inst_sram_addr_ok_i = 1'b0;
    inst_sram_data_ok_i = 1'b0;
    inst_sram_rdata_i = '0;
    m_pc = 32'h1c000000;

    // Reset state
    tick(); tick();
    check("rst_req", 130'(inst_sram_req_o), 130'(0));
    check("rst_valid", 130'({line2_valid_o, line1_valid_o}), 130'(0));
    check("rst_bus", to_id_obus, 130'(0));
    rst_n = 1'b1;

    // 1: first two-line packet, then sequential address
    do_fetch(64'h0000_0002_0000_0001);
    transfer();
    wait_req();
    check("seq_addr", 130'(inst_sram_addr_o), 130'(32'h1c000008));

    // 2: branch to odd word -> single line from the high half
    branch(32'h1c000104);
    do_fetch(64'haaaa_bbbb_cccc_dddd);
    transfer();
    check("pc_after_single", 130'(m_pc), 130'(32'h1c000108));

    // 3: back-pressure holds outputs; one transfer only
    do_fetch(64'h1111_2222_3333_4444);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_req", 130'(inst_sram_req_o), 130'(0));
      check("hold_valid", 130'({line2_valid_o, line1_valid_o}), 130'(2'b11));
      check("hold_bus", to_id_obus, {last_e.line2, last_e.line1});
    end
    transfer();
    allowin_i = 1'b1;
    tick(); tick();
    allowin_i = 1'b0;
    check("one_xfer_valid", 130'({line2_valid_o, line1_valid_o}), 130'(0));
    wait_req();
    check("addr_after_hold", 130'(inst_sram_addr_o), 130'(32'h1c000110));

    // 4: flush while waiting for data -> late response dropped
    inst_sram_addr_ok_i = 1'b1;
    tick();
    inst_sram_addr_ok_i = 1'b0;
    branch(32'h1c000200);
    for (int i = 0; i < 2; i++) begin
      check("discard_req", 130'(inst_sram_req_o), 130'(0));
      tick();
    end
    inst_sram_data_ok_i = 1'b1;
    inst_sram_rdata_i   = 64'hdead_beef_dead_beef;
    tick();
    inst_sram_data_ok_i = 1'b0;
    check("discard_valid", 130'({line2_valid_o, line1_valid_o}), 130'(0));
    do_fetch(64'h5555_6666_7777_8888);
    transfer();

    // 5: exception beats branch, flush coincides with accept
    wait_req();
    inst_sram_addr_ok_i = 1'b1;
    excep_flush_i       = 1'b1;
    excep_entry_i       = 32'h1c000300;
    branch_flush_i      = 1'b1;
    branch_target_i     = 32'h1c000400;
    tick();
    inst_sram_addr_ok_i = 1'b0;
    excep_flush_i       = 1'b0;
    branch_flush_i      = 1'b0;
    m_pc = 32'h1c000300;
    check("ex_discard_req", 130'(inst_sram_req_o), 130'(0));
    inst_sram_data_ok_i = 1'b1;
    tick();
    inst_sram_data_ok_i = 1'b0;
    check("ex_discard_valid", 130'({line2_valid_o, line1_valid_o}), 130'(0));
    do_fetch(64'h9999_aaaa_bbbb_cccc);
    transfer();

    // 6: misaligned branch -> ADEF line, then halt until redirect
    wait_req();
    branch(32'h1c000002);
    check("adef_no_req", 130'(inst_sram_req_o), 130'(0));
    e.l2v   = 1'b0;
    e.line1 = {1'b1, 32'h1c000002, 32'h0};
    e.line2 = '0;
    sb_q.push_back(e);
    tick();
    pop_check();
    allowin_i = 1'b1;
    tick();
    allowin_i = 1'b0;
    check("halt_valid", 130'({line2_valid_o, line1_valid_o}), 130'(0));
    for (int i = 0; i < 4; i++) begin
      tick();
      check("halt_req", 130'(inst_sram_req_o), 130'(0));
    end
    branch(32'h1c000500);
    check("recover_req", 130'(inst_sram_req_o), 130'(1));
    do_fetch(64'h0000_000b_0000_000a);
    check("sb_drained", 130'(sb_q.size()), 130'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
